// File: rtl/rtf65002_icachefill.sv
// rtf65002 I-cache line fill: bursts a 16-byte line from WISHBONE into one way.
// Define ICFILL_SETRR_EN for per-set round-robin way select (default: global flop).
module rtf65002_icachefill #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] req_adr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    output logic [31:0] adr_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic [31:0] dat_i,
    output logic        wr_o,
    output logic        whichwr_o,
    output logic [33:0] wadr_o,
    output logic [31:0] wdat_o
);

    typedef enum logic [1:0] {IDLE, FETCH, INVAL} state_t;

    localparam logic [7:0] TMO = 8'(BUS_TIMEOUT);

    state_t      state;
    logic [27:0] line;
    logic [1:0]  bc;
    logic [7:0]  tcnt;
    logic [7:0]  tnext;
    logic        rr_rd;
    logic        unused_adr;

`ifdef ICFILL_SETRR_EN
    logic [511:0] rr;
    assign rr_rd = rr[req_adr_i[12:4]];
`else
    logic rr;
    assign rr_rd = rr;
`endif

    assign tnext      = (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;
    assign bte_o      = 2'b00;
    assign unused_adr = ^req_adr_i[3:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            line      <= '0;
            bc        <= '0;
            tcnt      <= '0;
            rr        <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            cti_o     <= '0;
            adr_o     <= '0;
            wr_o      <= 1'b0;
            whichwr_o <= 1'b0;
            wadr_o    <= '0;
            wdat_o    <= '0;
        end else begin
            wr_o   <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // busy_o still high here means the tag write cycle
                    if (busy_o) begin
                        busy_o <= 1'b0;
                    end else if (req_i) begin
                        state     <= FETCH;
                        line      <= req_adr_i[31:4];
                        whichwr_o <= rr_rd;
                        bc        <= '0;
                        tcnt      <= '0;
                        busy_o    <= 1'b1;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        cti_o     <= 3'b010;
                        adr_o     <= {req_adr_i[31:4], 4'h0};
                    end
                end
                FETCH: begin
                    if (err_i || (!ack_i && tnext == TMO)) begin
                        state  <= INVAL;
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        cti_o  <= '0;
                        adr_o  <= '0;
                        wr_o   <= 1'b1;
                        err_o  <= 1'b1;
                        wadr_o <= {2'b00, line, 2'b11, 1'b0, 1'b0};
                    end else if (ack_i) begin
                        wr_o   <= 1'b1;
                        wdat_o <= dat_i;
                        wadr_o <= {2'b00, line, bc, 1'b0, 1'b1};
                        bc     <= bc + 2'd1;
                        tcnt   <= '0;
                        if (bc == 2'd3) begin
                            state  <= IDLE;
                            cyc_o  <= 1'b0;
                            stb_o  <= 1'b0;
                            cti_o  <= '0;
                            adr_o  <= '0;
                            done_o <= 1'b1;
`ifdef ICFILL_SETRR_EN
                            rr[line[8:0]] <= ~rr[line[8:0]];
`else
                            rr <= ~rr;
`endif
                        end else begin
                            adr_o <= {line, bc + 2'd1, 2'b00};
                            cti_o <= (bc == 2'd2) ? 3'b111 : 3'b010;
                        end
                    end else begin
                        tcnt <= tnext;
                    end
                end
                INVAL: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtf65002_icachefill.sv
// Randomized bench for rtf65002_icachefill against a transaction-level model.
// Build with ICFILL_SETRR_EN to check the per-set round-robin variant.
module tb_rtf65002_icachefill;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic        busy_o, done_o, err_o, cyc_o, stb_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] adr_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        wr_o, whichwr_o;
    logic [33:0] wadr_o;
    logic [31:0] wdat_o;

    int total = 0;
    int bad = 0;

    rtf65002_icachefill #(.BUS_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
        .req_adr_i(req_adr_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o),
        .bte_o(bte_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
        .dat_i(dat_i), .wr_o(wr_o), .whichwr_o(whichwr_o),
        .wadr_o(wadr_o), .wdat_o(wdat_o)
    );

    always #5 clk_i = ~clk_i;

    // way-select model
`ifdef ICFILL_SETRR_EN
    bit rrm [512];
    function automatic bit get_way(input logic [31:0] a);
        return rrm[a[12:4]];
    endfunction
    function automatic void flip(input logic [31:0] a);
        rrm[a[12:4]] = ~rrm[a[12:4]];
    endfunction
    function automatic void clr();
        foreach (rrm[i]) rrm[i] = 1'b0;
    endfunction
`else
    bit gw = 1'b0;
    function automatic bit get_way(input logic [31:0] a);
        return gw ^ (a[0] & 1'b0);
    endfunction
    function automatic void flip(input logic [31:0] a);
        gw = ~gw ^ (a[0] & 1'b0);
    endfunction
    function automatic void clr();
        gw = 1'b0;
    endfunction
`endif

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_busy(input logic [7:0] w, input int fb,
                                    input int kind);
        int n = 1;
        for (int b = 0; b < 4; b++) begin
            if (kind != 0 && b == fb)
                return n + ((kind == 2) ? TMO : int'(w[2*b+:2]) + 1);
            n += int'(w[2*b+:2]) + 1;
        end
        return n;
    endfunction

    task automatic beat_chk(input logic [27:0] ln, input logic [1:0] b,
                            input bit wy, input bit pend,
                            input logic [1:0] pb, input logic [31:0] pd);
        chk("cyc", cyc_o, 1);
        chk("stb", stb_o, 1);
        chk("adr", adr_o, {ln, b, 2'b00});
        chk("cti", cti_o, (b == 2'd3) ? 3'b111 : 3'b010);
        chk("bte", bte_o, 0);
        chk("wr", wr_o, pend);
        chk("done", done_o, 0);
        if (pend) begin
            chk("wadr", wadr_o, {2'b00, ln, pb, 1'b0, 1'b1});
            chk("wdat", wdat_o, pd);
            chk("way", whichwr_o, wy);
        end
    endtask

    // kind: 0 ok, 1 err_i on beat fb, 2 timeout on beat fb
    task automatic fill(input logic [31:0] a, input logic [7:0] w,
                        input int fb, input int kind, input bit hold,
                        input bit fixd);
        logic [27:0] ln;
        logic [1:0]  pb;
        logic [31:0] pd;
        bit          wy, pend, dead;
        int          bz, nw;
        ln = a[31:4];
        wy = get_way(a);
        pend = 0;
        dead = 0;
        bz = 0;
        pb = '0;
        pd = '0;
        req_i = 1'b1;
        req_adr_i = a;
        @(negedge clk_i);
        if (!hold) begin
            req_i = 1'b0;
            req_adr_i = $urandom;
        end
        for (int b = 0; b < 4 && !dead; b++) begin
            nw = (kind == 2 && b == fb) ? TMO : int'(w[2*b+:2]);
            for (int k = 0; k <= nw; k++) begin
                if (kind == 2 && b == fb && k == nw) begin
                    dead = 1;
                    break;
                end
                beat_chk(ln, b[1:0], wy, pend, pb, pd);
                bz += int'(busy_o);
                pend = 0;
                if (k == nw) begin
                    if (kind == 1 && b == fb) begin
                        err_i = 1'b1;
                        ack_i = 1'($urandom % 2);
                        dead = 1;
                    end else begin
                        pd = fixd ? 32'hA0 + b : $urandom;
                        dat_i = pd;
                        ack_i = 1'b1;
                        pb = b[1:0];
                        pend = 1;
                    end
                end
                @(negedge clk_i);
                ack_i = 1'b0;
                err_i = 1'b0;
                dat_i = $urandom;
            end
        end
        chk("end_wr", wr_o, 1);
        chk("end_cyc", cyc_o, 0);
        chk("end_stb", stb_o, 0);
        chk("end_way", whichwr_o, wy);
        bz += int'(busy_o);
        if (dead) begin
            chk("inval_wadr", wadr_o, {2'b00, ln, 2'b11, 1'b0, 1'b0});
            chk("inval_err", err_o, 1);
            chk("inval_done", done_o, 0);
        end else begin
            chk("tag_wadr", wadr_o, {2'b00, ln, 2'b11, 1'b0, 1'b1});
            chk("tag_wdat", wdat_o, pd);
            chk("tag_done", done_o, 1);
            chk("tag_err", err_o, 0);
            flip(a);
        end
        chk("busy_cnt", bz, exp_busy(w, fb, kind));
        @(negedge clk_i);
        chk("post_busy", busy_o, 0);
        chk("post_wr", wr_o, 0);
        chk("post_cyc", cyc_o, 0);
        chk("post_pulse", {done_o, err_o}, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {busy_o, done_o, err_o, cyc_o, stb_o, wr_o, whichwr_o}, 0);
        chk(tag, {cti_o, adr_o}, 0);
        chk(tag, {wadr_o, wdat_o}, 0);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        bit h;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        fill(32'h0000_1234, 8'h00, 0, 0, 0, 1);
        fill(32'h0000_1238, 8'hAA, 0, 0, 0, 0);
        fill(32'h0000_1230, 8'h05, 2, 1, 0, 0);
        fill(32'h0000_1230, 8'h00, 0, 0, 0, 0);
        fill(32'h0000_7770, 8'h00, 0, 2, 0, 0);
        fill(32'h0000_1230, 8'h00, 0, 0, 0, 0);
        fill(32'h0000_0450, 8'h00, 0, 0, 0, 0);
        fill(32'h0000_1238, 8'h00, 0, 0, 0, 0);
        fill(32'h0000_123C, 8'h00, 0, 0, 1, 0);
        fill(32'h0000_1234, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[12:4] = 9'h123 + 9'($urandom % 3);
            r = $urandom % 8;
            h = 1'($urandom % 2);
            fill(a, 8'($urandom), $urandom % 4,
                 (r == 0) ? 1 : (r == 1) ? 2 : 0, h, 0);
            if (!h) repeat ($urandom % 3) @(negedge clk_i);
        end

        // reset during beat 1 must abort without an invalidate
        req_i = 1'b1;
        req_adr_i = 32'h0000_5670;
        @(negedge clk_i);
        req_i = 1'b0;
        ack_i = 1'b1;
        dat_i = 32'h1234_5678;
        @(negedge clk_i);
        ack_i = 1'b0;
        chk("rst_pre_stb", stb_o, 1);
        #2 rst_ni = 1'b0;
        #1 chk_zero("rst_mid");
        clr();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_after", {wr_o, err_o, cyc_o}, 0);
        end
        fill(32'h0000_1230, 8'h00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
